// File: rtl/coord_uart_packer.sv
// Frames a coordinate snapshot into a fixed-length UART packet and paces bytes into uart_tx.
// Optional macro THRESH_ECHO_EN appends the four threshold bytes of thr_in before the checksum.
module coord_uart_packer #(
  parameter int UART_BPS = 9600,
  parameter int CLK_FREQ = 50_000_000,
  parameter int GAP_BITS = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        coord_vld,
  input  logic [10:0] coord_x,
  input  logic [10:0] coord_y,
  input  logic        found,
  input  logic [31:0] thr_in,
  output logic [7:0]  tx_data,
  output logic        tx_trig,
  output logic        busy,
  output logic        pkt_done,
  output logic        pkt_drop
);
  localparam int BIT_CNT = CLK_FREQ / UART_BPS;
  localparam int GAP     = BIT_CNT * GAP_BITS;
  localparam int CW      = $clog2(GAP + 1);
`ifdef THRESH_ECHO_EN
  localparam int NBYTES  = 12;
`else
  localparam int NBYTES  = 8;
`endif
  localparam logic [3:0] LAST = 4'(NBYTES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state;
  logic [3:0]    idx;
  logic [3:0]    sel;
  logic [CW-1:0] gap_cnt;
  logic [10:0]   snap_x, snap_y;
  logic          snap_f;
  logic [7:0]    csum;
  logic [7:0]    nxt_byte;

`ifdef THRESH_ECHO_EN
  logic [31:0]   snap_thr;
`else
  logic          unused_thr;
  assign unused_thr = ^thr_in;
`endif

  // Handshake outputs are pure state decodes, so they are 0 straight after reset.
  assign tx_trig  = (state == SEND);
  assign pkt_done = (state == DONE);
  assign busy     = (state != IDLE);
  assign pkt_drop = coord_vld && (state != IDLE);

  always_comb begin
    csum = {7'b0, snap_f} + {5'b0, snap_x[10:8]} + snap_x[7:0]
         + {5'b0, snap_y[10:8]} + snap_y[7:0];
`ifdef THRESH_ECHO_EN
    csum = csum + snap_thr[31:24] + snap_thr[23:16] + snap_thr[15:8] + snap_thr[7:0];
`endif
  end

  // Byte following the current one; B0 is loaded directly on acceptance.
  assign sel = idx + 4'd1;
  always_comb begin
    nxt_byte = 8'h00;
    case (sel)
      4'd0: nxt_byte = 8'h55;
      4'd1: nxt_byte = 8'hAA;
      4'd2: nxt_byte = {7'b0, snap_f};
      4'd3: nxt_byte = {5'b0, snap_x[10:8]};
      4'd4: nxt_byte = snap_x[7:0];
      4'd5: nxt_byte = {5'b0, snap_y[10:8]};
      4'd6: nxt_byte = snap_y[7:0];
`ifdef THRESH_ECHO_EN
      4'd7:  nxt_byte = snap_thr[31:24];
      4'd8:  nxt_byte = snap_thr[23:16];
      4'd9:  nxt_byte = snap_thr[15:8];
      4'd10: nxt_byte = snap_thr[7:0];
      4'd11: nxt_byte = csum;
`else
      4'd7: nxt_byte = csum;
`endif
      default: nxt_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      gap_cnt <= '0;
      tx_data <= '0;
    end else begin
      case (state)
        IDLE: if (coord_vld) begin
          idx     <= '0;
          tx_data <= 8'h55;
          state   <= SEND;
        end
        SEND: begin
          gap_cnt <= CW'(1);
          state   <= WAIT;
        end
        WAIT: if (gap_cnt == CW'(GAP - 1)) begin
          gap_cnt <= '0;
          if (idx == LAST) state <= DONE;
          else begin
            idx     <= sel;
            tx_data <= nxt_byte;
            state   <= SEND;
          end
        end else begin
          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Snapshot only loads on an accepted strobe, isolating queued bytes from live inputs.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && coord_vld) begin
      snap_x   <= coord_x;
      snap_y   <= coord_y;
      snap_f   <= found;
`ifdef THRESH_ECHO_EN
      snap_thr <= thr_in;
`endif
    end
  end
endmodule

// File: tb/tb_coord_uart_packer.sv
// Self-checking bench for coord_uart_packer (default 8-byte build, GAP = 110 cycles).
module tb_coord_uart_packer;
  localparam int GAP = 110;
  localparam int NB  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        coord_vld = 1'b0;
  logic [10:0] coord_x = '0;
  logic [10:0] coord_y = '0;
  logic        found = 1'b0;
  logic [31:0] thr_in = '0;
  logic [7:0]  tx_data;
  logic        tx_trig, busy, pkt_done, pkt_drop;

  coord_uart_packer #(.UART_BPS(100), .CLK_FREQ(1000), .GAP_BITS(11)) dut (
    .clk(clk), .rst(rst), .coord_vld(coord_vld), .coord_x(coord_x), .coord_y(coord_y),
    .found(found), .thr_in(thr_in), .tx_data(tx_data), .tx_trig(tx_trig), .busy(busy),
    .pkt_done(pkt_done), .pkt_drop(pkt_drop)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] trig_d[$];
  int         trig_c[$];
  int         done_c[$];
  int         drop_n = 0;
  int         busy_n = 0;
  int         n_chk = 0;
  int         n_fail = 0;
  int         t_last = 0;

  always @(negedge clk) begin
    if (tx_trig) begin
      trig_d.push_back(tx_data);
      trig_c.push_back(cyc);
    end
    if (pkt_done) done_c.push_back(cyc);
    if (pkt_drop) drop_n++;
    if (busy) busy_n++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // Reference packet: header, found, split coordinates, mod-256 sum of payload.
  function automatic logic [7:0] model_byte(input int x, input int y, input int f, input int k);
    int s;
    s = f + x / 256 + x % 256 + y / 256 + y % 256;
    case (k)
      0: return 8'h55;
      1: return 8'hAA;
      2: return 8'(f);
      3: return 8'(x / 256);
      4: return 8'(x % 256);
      5: return 8'(y / 256);
      6: return 8'(y % 256);
      7: return 8'(s % 256);
      default: return 8'h00;
    endcase
  endfunction

  task clear_mon();
    trig_d.delete(); trig_c.delete(); done_c.delete();
    drop_n = 0; busy_n = 0;
  endtask

  task pulse(input int x, input int y, input int f);
    coord_x = 11'(x); coord_y = 11'(y); found = f[0];
    thr_in = $urandom;
    coord_vld = 1'b1;
    t_last = cyc;
    @(posedge clk); #1;
    coord_vld = 1'b0;
  endtask

  task wait_done(output bit ok);
    int b;
    b = 0;
    while (done_c.size() == 0 && b < 2000) begin
      @(negedge clk); b++;
    end
    ok = (done_c.size() > 0);
  endtask

  task wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk); #1;
    end
  endtask

  task test_reset();
    rst = 1'b1;
    coord_vld = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({tx_data, tx_trig, busy, pkt_done, pkt_drop} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %03h expected 000", {tx_data, tx_trig, busy, pkt_done, pkt_drop});
    end
    coord_vld = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task test_packets();
    int x, y, f, t0;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin x = 640; y = 360; f = 1; end
      else if (i == 1) begin x = 2047; y = 0; f = 0; end
      else begin x = $urandom_range(2047); y = $urandom_range(2047); f = $urandom_range(1); end
      clear_mon();
      pulse(x, y, f);
      t0 = t_last;
      wait_done(ok);
      n_chk++;
      if (!ok) begin n_fail++; $display("FAIL pkt%0d_done_timeout: got none expected pkt_done", i); end
      n_chk++;
      if (trig_d.size() != NB) begin
        n_fail++; $display("FAIL pkt%0d_trig_count: got %0d expected %0d", i, trig_d.size(), NB);
      end
      for (int k = 0; k < NB && k < trig_d.size(); k++) begin
        n_chk++;
        if (trig_d[k] !== model_byte(x, y, f, k)) begin
          n_fail++; $display("FAIL pkt%0d_byte%0d: got %02h expected %02h", i, k, trig_d[k], model_byte(x, y, f, k));
        end
        n_chk++;
        if (trig_c[k] != t0 + 1 + k * GAP) begin
          n_fail++; $display("FAIL pkt%0d_trig%0d_cycle: got %0d expected %0d", i, k, trig_c[k], t0 + 1 + k * GAP);
        end
      end
      if (ok) begin
        n_chk++;
        if (done_c[0] != t0 + 1 + NB * GAP) begin
          n_fail++; $display("FAIL pkt%0d_done_cycle: got %0d expected %0d", i, done_c[0], t0 + 1 + NB * GAP);
        end
      end
      @(negedge clk);
      n_chk++;
      if (busy_n != NB * GAP + 1) begin
        n_fail++; $display("FAIL pkt%0d_busy_cycles: got %0d expected %0d", i, busy_n, NB * GAP + 1);
      end
      @(posedge clk); #1;
    end
  endtask

  task test_drop();
    int t0;
    bit ok;
    clear_mon();
    pulse(100, 200, 1);
    t0 = t_last;
    wait_cyc(t0 + 50);
    pulse(5, 6, 0);
    wait_cyc(t0 + 1 + NB * GAP);
    pulse(7, 8, 1);
    wait_done(ok);
    repeat (300) @(posedge clk);
    #1;
    n_chk++;
    if (drop_n != 2) begin n_fail++; $display("FAIL drop_count: got %0d expected 2", drop_n); end
    n_chk++;
    if (trig_d.size() != NB || done_c.size() != 1) begin
      n_fail++; $display("FAIL drop_trig_count: got %0d/%0d expected %0d/1", trig_d.size(), done_c.size(), NB);
    end
    for (int k = 0; k < NB && k < trig_d.size(); k++) begin
      n_chk++;
      if (trig_d[k] !== model_byte(100, 200, 1, k)) begin
        n_fail++; $display("FAIL drop_byte%0d: got %02h expected %02h", k, trig_d[k], model_byte(100, 200, 1, k));
      end
    end
    if (ok) begin
      n_chk++;
      if (done_c[0] != t0 + 1 + NB * GAP) begin
        n_fail++; $display("FAIL drop_done_cycle: got %0d expected %0d", done_c[0], t0 + 1 + NB * GAP);
      end
    end
  endtask

  task test_reset_mid();
    int b, n;
    bit ok;
    clear_mon();
    pulse(640, 360, 1);
    b = 0;
    while (trig_d.size() < 3 && b < 1000) begin @(negedge clk); b++; end
    n_chk++;
    if (trig_d.size() < 3) begin n_fail++; $display("FAIL rstmid_trig_timeout: got %0d expected 3", trig_d.size()); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({tx_data, tx_trig, busy, pkt_done, pkt_drop} !== 12'h000) begin
      n_fail++; $display("FAIL rstmid_outputs: got %03h expected 000", {tx_data, tx_trig, busy, pkt_done, pkt_drop});
    end
    n = trig_d.size();
    rst = 1'b0;
    repeat (400) @(posedge clk);
    #1;
    n_chk++;
    if (trig_d.size() != n || busy !== 1'b0 || done_c.size() != 0) begin
      n_fail++; $display("FAIL rstmid_quiet: got trig=%0d busy=%0b done=%0d expected trig=%0d busy=0 done=0", trig_d.size(), busy, done_c.size(), n);
    end
    clear_mon();
    pulse(3, 4, 1);
    wait_done(ok);
    n_chk++;
    if (!ok || trig_d.size() != NB) begin
      n_fail++; $display("FAIL rstmid_restart: got trig=%0d expected %0d", trig_d.size(), NB);
    end
    for (int k = 0; k < NB && k < trig_d.size(); k++) begin
      n_chk++;
      if (trig_d[k] !== model_byte(3, 4, 1, k)) begin
        n_fail++; $display("FAIL rstmid_byte%0d: got %02h expected %02h", k, trig_d[k], model_byte(3, 4, 1, k));
      end
    end
    @(posedge clk); #1;
  endtask

  task test_isolation();
    int t0;
    bit ok;
    clear_mon();
    pulse(1234, 567, 1);
    t0 = t_last;
    wait_cyc(t0 + 5);
    coord_x = 11'd77; coord_y = 11'd1900; found = 1'b0; thr_in = $urandom;
    wait_done(ok);
    n_chk++;
    if (!ok || trig_d.size() != NB) begin
      n_fail++; $display("FAIL iso_trig_count: got %0d expected %0d", trig_d.size(), NB);
    end
    for (int k = 0; k < NB && k < trig_d.size(); k++) begin
      n_chk++;
      if (trig_d[k] !== model_byte(1234, 567, 1, k)) begin
        n_fail++; $display("FAIL iso_byte%0d: got %02h expected %02h", k, trig_d[k], model_byte(1234, 567, 1, k));
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_packets();
    test_drop();
    test_reset_mid();
    test_isolation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
